// File: rtl/sprite_animator_pkg.sv
// Shared types and constants for the sprite animator slice.
// Optional build macro: SPRITE_FLIP_EN (horizontal mirror support).
package sprite_pkg;

    localparam int COORD_W  = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } anim_state_t;

    // $clog2 that never yields a zero-width vector.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/sprite_animator_if.sv
// Sprite ROM bus: registered address out, synchronous read data back one cycle later.
// Optional build macro: SPRITE_FLIP_EN (no effect on this bus).
interface sprite_animator_if #(
    parameter int IDX_W  = 3,
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] rom_address;
    logic [IDX_W-1:0]  rom_q;

    // The renderer drives the address; the ROM returns data.
    modport master (output rom_address, input rom_q);
    modport slave  (input rom_address, output rom_q);
endinterface

// File: rtl/sprite_anim_ctrl.sv
// Animation sequencer: IDLE/PLAY/DONE FSM with tick and frame counters.
// Paced by frame_start; play restarts from frame 0 and overrides a same-cycle tick.
// Optional build macro: SPRITE_FLIP_EN (no effect on this module).
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int FRAMES      = 4,
    parameter int FRAME_TICKS = 6,
    parameter int FW          = 2
) (
    input  logic          vga_clk,
    input  logic          reset_n,
    input  logic          frame_start,
    input  logic          play,
    input  logic          loop_mode,
    output logic [FW-1:0] anim_frame,
    output logic          anim_done,
    output logic [1:0]    anim_state
);
    localparam int TW = clog2_min1(FRAME_TICKS);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_PLAY = PLAY;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          done_q, done_d;

    // Next-state: play restarts; otherwise frame_start advances tick/frame while playing.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        frame_d = frame_q;
        done_d  = done_q;
        if (play) begin
            state_d = ST_PLAY;
            tick_d  = '0;
            frame_d = '0;
            done_d  = 1'b0;
        end else if (frame_start && state_q == ST_PLAY) begin
            if (tick_q == TW'(FRAME_TICKS - 1)) begin
                tick_d = '0;
                if (frame_q == FW'(FRAMES - 1)) begin
                    // loop_mode only matters here, at the last-frame decision.
                    if (loop_mode) begin
                        frame_d = '0;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    frame_d = frame_q + 1'b1;
                end
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
    end

    // State registers, cleared asynchronously to IDLE / frame 0.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            frame_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end

    assign anim_frame = frame_q;
    assign anim_done  = done_q;
    assign anim_state = state_q;

endmodule

// File: rtl/sprite_animator.sv
// Positioned, upscaled, multi-frame sprite renderer. Pixel path is 3 cycles
// from DrawX/DrawY/blank to pix_index/pix_valid, one pixel per cycle:
//   N: hit test + local offsets, N+1: rom_address, N+2: rom_q, N+3: outputs.
// Optional build macro: SPRITE_FLIP_EN enables the horizontal mirror on flip.
module sprite_animator
    import sprite_pkg::*;
#(
    parameter int W           = 50,
    parameter int H           = 64,
    parameter int FRAMES      = 4,
    parameter int SCALE_SH    = 0,
    parameter int IDX_W       = 3,
    parameter int TRANSP_IDX  = 0,
    parameter int FRAME_TICKS = 6,
    parameter int ADDR_W      = $clog2(FRAMES * W * H),
    localparam int FW         = clog2_min1(FRAMES)
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    input  logic               blank,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] sprite_x,
    input  logic [COORD_W-1:0] sprite_y,
    input  logic               enable,
    input  logic               play,
    input  logic               loop_mode,
    input  logic               flip,
    sprite_animator_if.master  rom,
    output logic [IDX_W-1:0]   pix_index,
    output logic               pix_valid,
    output logic [FW-1:0]      anim_frame,
    output logic               anim_done,
    output logic [1:0]         anim_state
);
    localparam int CW1  = COORD_W + 1;
    localparam int LX_W = clog2_min1(W);
    localparam int LY_W = clog2_min1(H);
    localparam logic [COORD_W:0]  SPAN_X   = CW1'(W << SCALE_SH);
    localparam logic [COORD_W:0]  SPAN_Y   = CW1'(H << SCALE_SH);
    localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(W * H);
    localparam logic [ADDR_W-1:0] ROW_SZ   = ADDR_W'(W);

    logic [COORD_W-1:0] pos_x_q, pos_y_q;
    logic [COORD_W:0]   dx_c, dy_c;
    logic               in_box_c;
    logic [LX_W-1:0]    lx_c, lx_s1_q;
    logic [LY_W-1:0]    ly_c, ly_s1_q;
    logic               in_box_s1_q, vis_s1_q, show_s2_q, show_s3_q;
    logic [ADDR_W-1:0]  rom_address_d, rom_address_q;
    logic [IDX_W-1:0]   pix_index_q;
    logic               pix_valid_q;

    sprite_anim_ctrl #(
        .FRAMES      (FRAMES),
        .FRAME_TICKS (FRAME_TICKS),
        .FW          (FW)
    ) u_ctrl (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .play        (play),
        .loop_mode   (loop_mode),
        .anim_frame  (anim_frame),
        .anim_done   (anim_done),
        .anim_state  (anim_state)
    );

    // Position is taken once per video frame so the sprite never tears mid-frame.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x_q <= '0;
            pos_y_q <= '0;
        end else if (frame_start) begin
            pos_x_q <= sprite_x;
            pos_y_q <= sprite_y;
        end
    end

`ifdef SPRITE_FLIP_EN
    logic flip_q;
    // Mirror select travels with the position so it also switches only between frames.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n)         flip_q <= 1'b0;
        else if (frame_start) flip_q <= flip;
    end
`else
    logic unused_flip;
    assign unused_flip = flip;
`endif

    // Hit test in 11 bits (no wrap at the screen edge) and sprite-local offsets.
    always_comb begin
        dx_c     = {1'b0, DrawX} - {1'b0, pos_x_q};
        dy_c     = {1'b0, DrawY} - {1'b0, pos_y_q};
        in_box_c = (DrawX >= pos_x_q) && (dx_c < SPAN_X) &&
                   (DrawY >= pos_y_q) && (dy_c < SPAN_Y);
        lx_c     = '0;
        ly_c     = '0;
        // Offsets are forced to 0 outside the box so the address stays in range.
        if (in_box_c) begin
            lx_c = LX_W'(dx_c >> SCALE_SH);
            ly_c = LY_W'(dy_c >> SCALE_SH);
`ifdef SPRITE_FLIP_EN
            if (flip_q) lx_c = LX_W'(W - 1) - lx_c;
`endif
        end
    end

    // ROM address: frame base plus row/column, all constant multiplies.
    always_comb begin
        rom_address_d = ADDR_W'(anim_frame) * FRAME_SZ
                      + ADDR_W'(ly_s1_q) * ROW_SZ
                      + ADDR_W'(lx_s1_q);
    end

    // Pixel pipeline: visibility flags ride alongside the address/data.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            in_box_s1_q   <= 1'b0;
            vis_s1_q      <= 1'b0;
            lx_s1_q       <= '0;
            ly_s1_q       <= '0;
            rom_address_q <= '0;
            show_s2_q     <= 1'b0;
            show_s3_q     <= 1'b0;
            pix_index_q   <= '0;
            pix_valid_q   <= 1'b0;
        end else begin
            in_box_s1_q   <= in_box_c;
            vis_s1_q      <= blank & enable;
            lx_s1_q       <= lx_c;
            ly_s1_q       <= ly_c;
            rom_address_q <= rom_address_d;
            show_s2_q     <= in_box_s1_q & vis_s1_q;
            show_s3_q     <= show_s2_q;
            pix_index_q   <= rom.rom_q;
            pix_valid_q   <= show_s3_q && (rom.rom_q != IDX_W'(TRANSP_IDX));
        end
    end

    assign rom.rom_address = rom_address_q;
    assign pix_index       = pix_index_q;
    assign pix_valid       = pix_valid_q;

endmodule

// File: tb/tb_sprite_animator.sv
// Bench for sprite_animator: two instances (SCALE_SH=0 at (100,200), SCALE_SH=1
// at (0,0) with flip tied high), ROM models returning address mod 8, TRANSP_IDX=7.
// Optional build macro: SPRITE_FLIP_EN changes the expected addresses of the second instance.
module tb_sprite_animator;
    import sprite_pkg::*;

    localparam int W = 50, H = 64, FRAMES = 4, IDX_W = 3, TRANSP = 7, FT = 6;
    localparam int ADDR_W = $clog2(FRAMES * W * H);

    // ---------------- clock / reset ----------------
    logic vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;
    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    logic       reset_n, blank, frame_start, enable, play, loop_mode;
    logic [9:0] DrawX, DrawY;
    logic [IDX_W-1:0] pix_index0, pix_index1;
    logic       pix_valid0, pix_valid1, anim_done0, anim_done1;
    logic [1:0] anim_frame0, anim_frame1, anim_state0, anim_state1;

    sprite_animator_if #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) rom0 ();
    sprite_animator_if #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) rom1 ();

    // Synchronous ROMs: content is address mod 8.
    always @(posedge vga_clk) rom0.rom_q <= rom0.rom_address[2:0];
    always @(posedge vga_clk) rom1.rom_q <= rom1.rom_address[2:0];

    sprite_animator #(.W(W), .H(H), .FRAMES(FRAMES), .SCALE_SH(0), .IDX_W(IDX_W),
                      .TRANSP_IDX(TRANSP), .FRAME_TICKS(FT), .ADDR_W(ADDR_W)) dut0 (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .frame_start(frame_start), .sprite_x(10'd100), .sprite_y(10'd200), .enable(enable),
        .play(play), .loop_mode(loop_mode), .flip(1'b0), .rom(rom0),
        .pix_index(pix_index0), .pix_valid(pix_valid0), .anim_frame(anim_frame0),
        .anim_done(anim_done0), .anim_state(anim_state0));

    sprite_animator #(.W(W), .H(H), .FRAMES(FRAMES), .SCALE_SH(1), .IDX_W(IDX_W),
                      .TRANSP_IDX(TRANSP), .FRAME_TICKS(FT), .ADDR_W(ADDR_W)) dut1 (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .frame_start(frame_start), .sprite_x(10'd0), .sprite_y(10'd0), .enable(enable),
        .play(play), .loop_mode(loop_mode), .flip(1'b1), .rom(rom1),
        .pix_index(pix_index1), .pix_valid(pix_valid1), .anim_frame(anim_frame1),
        .anim_done(anim_done1), .anim_state(anim_state1));

    // ---------------- scoreboard ----------------
    typedef struct { int due; int dut; logic [ADDR_W-1:0] addr; } addr_exp_t;
    typedef struct { int due; int dut; logic v; logic [IDX_W-1:0] idx; logic ci; } pix_exp_t;
    typedef struct { int due; logic [1:0] frame; logic done; logic [1:0] st; } anim_exp_t;

    addr_exp_t   addr_q[$];
    pix_exp_t    pix_q[$];
    anim_exp_t   anim_q[$];
    logic [31:0] exp_q[$];   // expected value of every output right after reset assertion

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void late(input string nm, input int due);
        total++;
        bad++;
        $display("FAIL %s: expected response due at cycle %0d never checked (cycle %0d)", nm, due, cyc);
    endfunction

    // Monitor: compare every due expectation against the DUT on the falling edge.
    always @(negedge vga_clk) begin : monitor
        addr_exp_t ae;
        pix_exp_t  pe;
        anim_exp_t ne;
        while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
            ae = addr_q.pop_front();
            if (ae.due < cyc) late("rom_address", ae.due);
            else if (ae.dut == 0) chk("rom_address0", 32'(rom0.rom_address), 32'(ae.addr));
            else                  chk("rom_address1", 32'(rom1.rom_address), 32'(ae.addr));
        end
        while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
            pe = pix_q.pop_front();
            if (pe.due < cyc) late("pixel", pe.due);
            else if (pe.dut == 0) begin
                chk("pix_valid0", 32'(pix_valid0), 32'(pe.v));
                if (pe.ci) chk("pix_index0", 32'(pix_index0), 32'(pe.idx));
            end else begin
                chk("pix_valid1", 32'(pix_valid1), 32'(pe.v));
                if (pe.ci) chk("pix_index1", 32'(pix_index1), 32'(pe.idx));
            end
        end
        while (anim_q.size() > 0 && anim_q[0].due <= cyc) begin
            ne = anim_q.pop_front();
            if (ne.due < cyc) late("anim", ne.due);
            else begin
                chk("anim_frame0", 32'(anim_frame0), 32'(ne.frame));
                chk("anim_done0",  32'(anim_done0),  32'(ne.done));
                chk("anim_state0", 32'(anim_state0), 32'(ne.st));
                chk("anim_frame1", 32'(anim_frame1), 32'(ne.frame));
            end
        end
    end

    // Reset monitor: outputs must clear immediately on reset assertion.
    always @(negedge reset_n) begin : rst_monitor
        logic [31:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            #1;
            chk("rst_rom_address", 32'(rom0.rom_address), e);
            chk("rst_pix_index",   32'(pix_index0),       e);
            chk("rst_pix_valid",   32'(pix_valid0),       e);
            chk("rst_anim_frame",  32'(anim_frame0),      e);
            chk("rst_anim_done",   32'(anim_done0),       e);
            chk("rst_anim_state",  32'(anim_state0),      32'(IDLE));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic px(input int x, input int y, input logic b, input logic e, input int dut,
                      input logic ca, input int a, input logic v, input int idx, input logic ci);
        @(negedge vga_clk);
        DrawX  = 10'(x);
        DrawY  = 10'(y);
        blank  = b;
        enable = e;
        if (ca) addr_q.push_back('{cyc + 2, dut, ADDR_W'(a)});
        pix_q.push_back('{cyc + 4, dut, v, IDX_W'(idx), ci});
    endtask

    task automatic pulse(input logic p, input logic f, input logic ck,
                         input int ef, input logic ed, input logic [1:0] es);
        @(negedge vga_clk);
        play        = p;
        frame_start = f;
        if (ck) anim_q.push_back('{cyc + 1, 2'(ef), ed, es});
        @(negedge vga_clk);
        play        = 1'b0;
        frame_start = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        reset_n = 1'b1; blank = 1'b0; enable = 1'b1; play = 1'b0;
        frame_start = 1'b0; loop_mode = 1'b0; DrawX = '0; DrawY = '0;
        exp_q.push_back(32'd0);
        #3 reset_n = 1'b0;
        #20;
        @(negedge vga_clk) reset_n = 1'b1;

        // Latch positions; FSM sits in IDLE and ignores frame_start.
        pulse(1'b0, 1'b1, 1'b1, 0, 1'b0, IDLE);

        // dut0: (100,200), 50x64, scale 1
        px(100, 200, 1, 1, 0, 1, 0,    1, 0, 1);
        px(149, 200, 1, 1, 0, 1, 49,   1, 1, 1);
        px(150, 200, 1, 1, 0, 0, 0,    0, 0, 0);
        px(107, 200, 1, 1, 0, 1, 7,    0, 7, 1);   // transparent index
        px(101, 201, 0, 1, 0, 1, 51,   0, 3, 1);   // blank low
        px(101, 201, 1, 0, 0, 1, 51,   0, 3, 1);   // enable low
        px(102, 263, 1, 1, 0, 1, 3152, 1, 0, 1);   // last row
        px(102, 264, 1, 1, 0, 0, 0,    0, 0, 0);   // below the box
        px(99,  200, 1, 1, 0, 0, 0,    0, 0, 0);   // left of the box
        // dut1: (0,0), 100x128 on screen, flip input high
`ifdef SPRITE_FLIP_EN
        px(3,  5,   1, 1, 1, 1, 148,  1, 4, 1);
        px(0,  0,   1, 1, 1, 1, 49,   1, 1, 1);
        px(99, 127, 1, 1, 1, 1, 3150, 1, 6, 1);
`else
        px(3,  5,   1, 1, 1, 1, 101,  1, 5, 1);
        px(0,  0,   1, 1, 1, 1, 0,    1, 0, 1);
        px(99, 127, 1, 1, 1, 1, 3199, 0, 7, 1);
`endif
        px(100, 5, 1, 1, 1, 0, 0, 0, 0, 0);        // right of the scaled box
        @(negedge vga_clk) blank = 1'b0;
        repeat (6) @(negedge vga_clk);

        // One-shot: 24 frame_starts walk frames 0..3 then finish.
        loop_mode = 1'b0;
        pulse(1'b1, 1'b0, 1'b1, 0, 1'b0, PLAY);
        for (int n = 1; n <= 24; n++)
            pulse(1'b0, 1'b1, 1'b1, (n / 6 > 3) ? 3 : n / 6, n == 24, (n == 24) ? DONE : PLAY);
        for (int n = 0; n < 2; n++)
            pulse(1'b0, 1'b1, 1'b1, 3, 1'b1, DONE);
        pulse(1'b1, 1'b0, 1'b1, 0, 1'b0, PLAY);

        // play with frame_start at frame 1 tick 5: restart, tick not counted.
        for (int n = 1; n <= 11; n++)
            pulse(1'b0, 1'b1, 1'b1, n / 6, 1'b0, PLAY);
        pulse(1'b1, 1'b1, 1'b1, 0, 1'b0, PLAY);
        for (int n = 1; n <= 6; n++)
            pulse(1'b0, 1'b1, 1'b1, n / 6, 1'b0, PLAY);

        // Loop mode wraps back to frame 0 after the last frame.
        loop_mode = 1'b1;
        pulse(1'b1, 1'b0, 1'b1, 0, 1'b0, PLAY);
        for (int n = 1; n <= 24; n++)
            pulse(1'b0, 1'b1, 1'b1, (n / 6) % 4, 1'b0, PLAY);

        // Mid-animation reset with a busy pixel path (frame 1, address 3251).
        for (int n = 1; n <= 7; n++)
            pulse(1'b0, 1'b1, 1'b0, 0, 1'b0, PLAY);
        @(negedge vga_clk);
        DrawX = 10'd101; DrawY = 10'd201; blank = 1'b1; enable = 1'b1;
        repeat (6) @(negedge vga_clk);
        exp_q.push_back(32'd0);
        @(posedge vga_clk);
        #2 reset_n = 1'b0;
        #10;
        @(negedge vga_clk) reset_n = 1'b1;
        blank = 1'b0;
        pulse(1'b0, 1'b0, 1'b1, 0, 1'b0, IDLE);

        repeat (10) @(negedge vga_clk);
        while (addr_q.size() > 0) late("rom_address", addr_q.pop_front().due);
        while (pix_q.size() > 0)  late("pixel", pix_q.pop_front().due);
        while (anim_q.size() > 0) late("anim", anim_q.pop_front().due);
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            late("reset", cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_animator.md
# sprite_animator

Parametrised, positioned, animated sprite renderer for the VGA pipeline. Each instance places one multi-frame sprite (W×H pixels per frame, FRAMES frames, integer power-of-two upscale) at a run-time screen position. It plays a loop or one-shot animation paced by frame-start pulses and streams a palette index plus an opaque/valid flag to the layer compositor. Sprite ROM and palette are external. The block drives the ROM address and consumes a synchronous ROM read.

## Interface
Parameters:
- `W`, 50: sprite frame width in pixels.
- `H`, 64: sprite frame height in pixels.
- `FRAMES`, 4: frame count, stored consecutively in the ROM, frame-major.
- `SCALE_SH`, 0: upscale shift; on-screen size is (W<<SCALE_SH)×(H<<SCALE_SH).
- `IDX_W`, 3: palette index width.
- `TRANSP_IDX`, 0: palette index treated as transparent.
- `FRAME_TICKS`, 6: frame_start pulses per animation frame, ≥1.
- `ADDR_W`, $clog2(FRAMES*W*H): ROM address width.

Ports:
- `vga_clk` in 1: sole clock, all logic on posedge.
- `reset_n` in 1: asynchronous active-low reset.
- `DrawX`, `DrawY` in 10 each: current pixel coordinate.
- `blank` in 1: 1 = active display region.
- `frame_start` in 1: one-cycle pulse at vertical-sync start.
- `sprite_x`, `sprite_y` in 10 each: top-left on-screen position.
- `enable` in 1: 0 forces pix_valid low; animation keeps running.
- `play` in 1: one-cycle pulse that restarts the animation.
- `loop_mode` in 1: 1 = loop, 0 = one-shot.
- `flip` in 1: horizontal mirror, used only with SPRITE_FLIP_EN.
- `rom_q` in IDX_W: ROM data, valid one cycle after rom_address.
- `rom_address` out ADDR_W: registered ROM address.
- `pix_index` out IDX_W: palette index.
- `pix_valid` out 1: pixel is opaque, inside the sprite, blank=1, and enable=1.
- `anim_frame` out $clog2(FRAMES): current frame number.
- `anim_done` out 1: one-shot animation has finished.

## Operation
- Position latch: sprite_x/sprite_y are captured into pos_x/pos_y on frame_start, so there is no mid-frame tearing. Reset value is 0,0.
- Hit test: in-box when pos_x ≤ DrawX < pos_x+(W<<SCALE_SH), and the same on Y. Comparisons are 11-bit, so no wrap. A sprite partly off the right or bottom edge clips cleanly.
- Local coordinates: lx=(DrawX−pos_x)>>SCALE_SH, ly=(DrawY−pos_y)>>SCALE_SH. Address = anim_frame*W*H + ly*W + lx, computed as the sum of constant multiplies.
- Animation FSM states:
  - IDLE: frame 0, done 0. This is the reset state.
  - PLAY: on each frame_start, tick++. When tick==FRAME_TICKS−1, tick←0 and frame++.
  - At the last frame with loop_mode=1: frame←0, stay in PLAY.
  - At the last frame with loop_mode=0: go to DONE, hold frame FRAMES−1, anim_done=1.
  - DONE: holds until play.
- play in any state → PLAY, frame←0, tick←0, anim_done←0.
- play together with frame_start in the same cycle: play wins and no tick is counted.
- loop_mode is sampled at the last-frame decision only.
- Transparency: rom_q==TRANSP_IDX → pix_valid=0. pix_index still carries rom_q.
- Reset values: rom_address 0, pix_index 0, pix_valid 0, anim_frame 0, anim_done 0, FSM IDLE, tick 0. Reset asserted mid-animation returns everything to these values immediately (asynchronous).

## Timing
- Pipeline latency is 3 cycles from DrawX/DrawY/blank to pix_index/pix_valid:
  - Edge N: register the in-box flag and local offsets.
  - Edge N+1: rom_address registered.
  - Edge N+2: rom_q valid (external ROM, 1-cycle synchronous read).
  - Edge N+3: outputs registered.
- in-box, blank and enable are delayed alongside the data so they stay aligned.
- anim_frame changes only on the edge that samples frame_start or play. The address stage uses anim_frame directly; the change lands during vertical blank.
- Throughput: one pixel per cycle with no stalls.

## Configuration
- `SPRITE_FLIP_EN` defined: when flip=1, lx′=W−1−lx. flip is latched with the position on frame_start.
- `SPRITE_FLIP_EN` undefined: the flip port is present but ignored, and no mirror logic is built.
- Latency is identical in both builds.

## Structure
- Package `sprite_pkg`: anim_state_t enum (IDLE, PLAY, DONE), the screen constants SCREEN_W=640 and SCREEN_H=480, and the coordinate width constant COORD_W=10.
- Sub-module `sprite_anim_ctrl`: the FSM plus tick and frame counters. Its inputs are frame_start, play and loop_mode; its outputs are anim_frame and anim_done.

## Test plan
- Position (100,200), SCALE_SH=0, ROM filled with address mod 8 → DrawX=100,DrawY=200: rom_address=0 and pix_valid=1 three cycles later. DrawX=149: address 49. DrawX=150: pix_valid=0.
- SCALE_SH=1 at position (0,0) → DrawX=3,DrawY=5: address = 2*50+1 = 101.
- rom_q=TRANSP_IDX inside the box → pix_valid=0. blank=0 or enable=0 → pix_valid=0.
- loop_mode=0, play, 24 frame_start pulses (FRAME_TICKS=6, FRAMES=4) → anim_frame steps 0→1→2→3, anim_done=1, stays at 3. A further play → frame 0, anim_done=0.
- play and frame_start asserted together while in PLAY at tick 5 → frame 0, tick 0. Reset_n pulsed mid-animation → all outputs at their reset values that cycle.
- With SPRITE_FLIP_EN, flip=1 at position (0,0) → DrawX=0: address 49. Without the macro: address 0.
